// File: rtl/match_round_controller.sv
// -----------------------------------------------------------------------------
// match_round_controller
//
// Best-of-N match sequencer for the fighting game. A free-running divider
// produces a one-clock game tick. Every phase transition, countdown and score
// update happens only in tick cycles, so the whole match runs in game time
// instead of clock time.
//
// Phases: INTRO (round_reset held) -> FIGHT (fight_en held) -> KO -> either
// the next round's INTRO or MATCH_OVER. Holding restart_req for HOLD_TICKS
// consecutive ticks restarts the match from any phase.
//
// Ports
//   clk          : system clock
//   reset        : asynchronous, active-low reset
//   restart_req  : level restart request, synchronous to clk
//   health_1/2   : player health, 0 means knocked out
//   tick         : one-clock game-tick pulse
//   round_reset  : high throughout INTRO, clears round-scoped blocks
//   fight_en     : high only during FIGHT
//   state        : 0 INTRO, 1 FIGHT, 2 KO, 3 MATCH_OVER
//   round_num    : current round, 1-based
//   wins_1/2     : round wins per player, saturating at ROUNDS_TO_WIN
//   round_winner : 0 none, 1 P1, 2 P2, 3 draw (last decided round)
//   winner       : 0 in progress, 1 P1, 2 P2, 3 match draw
//   time_left    : ticks remaining in the current fight
// -----------------------------------------------------------------------------
module match_round_controller #(
    parameter int TICK_DIV      = 2500000,
    parameter int HEALTH_W      = 9,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 5,
    parameter int ROUND_TICKS   = 1200,
    parameter int INTRO_TICKS   = 60,
    parameter int KO_TICKS      = 60,
    parameter int HOLD_TICKS    = 40,
    parameter int TIME_W        = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                restart_req,
    input  logic [HEALTH_W-1:0] health_1,
    input  logic [HEALTH_W-1:0] health_2,
    output logic                tick,
    output logic                round_reset,
    output logic                fight_en,
    output logic [2:0]          state,
    output logic [3:0]          round_num,
    output logic [3:0]          wins_1,
    output logic [3:0]          wins_2,
    output logic [1:0]          round_winner,
    output logic [2:0]          winner,
    output logic [TIME_W-1:0]   time_left
);

    // The phase counter is shared by INTRO and KO, so it is sized for the
    // longer of the two.
    localparam int PHASE_MAX = (INTRO_TICKS > KO_TICKS) ? INTRO_TICKS : KO_TICKS;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int HOLD_W    = $clog2(HOLD_TICKS + 1);
    localparam int DIV_W     = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        ST_INTRO      = 3'd0,
        ST_FIGHT      = 3'd1,
        ST_KO         = 3'd2,
        ST_MATCH_OVER = 3'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick_q, tick_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [3:0]          round_q, round_d;
    logic [3:0]          wins1_q, wins1_d;
    logic [3:0]          wins2_q, wins2_d;
    logic [1:0]          rwin_q, rwin_d;
    logic [2:0]          winner_q, winner_d;
    logic [TIME_W-1:0]   time_q, time_d;
    logic                round_reset_q, round_reset_d;
    logic                fight_en_q, fight_en_d;
    logic                decided;

    // Win counters stop at the target so a stray extra win cannot wrap them.
    function automatic logic [3:0] sat_inc(input logic [3:0] value);
        return (value < 4'(ROUNDS_TO_WIN)) ? value + 4'd1 : value;
    endfunction

    // Next-state logic. The divider runs every clock; everything else only
    // advances in the tick cycle. A completed restart hold overrides any
    // transition the current phase would otherwise make.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        hold_d    = hold_q;
        round_d   = round_q;
        wins1_d   = wins1_q;
        wins2_d   = wins2_q;
        rwin_d    = rwin_q;
        winner_d  = winner_q;
        time_d    = time_q;
        decided   = 1'b0;

        div_d  = (div_q == DIV_W'(TICK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
        tick_d = (div_d == DIV_W'(TICK_DIV - 1));

        if (tick_q) begin
            hold_d = restart_req ? hold_q + HOLD_W'(1) : '0;

            if (restart_req && (hold_q == HOLD_W'(HOLD_TICKS - 1))) begin
                state_d  = ST_INTRO;
                phase_d  = '0;
                hold_d   = '0;
                round_d  = 4'd1;
                wins1_d  = 4'd0;
                wins2_d  = 4'd0;
                rwin_d   = 2'd0;
                winner_d = 3'd0;
                time_d   = TIME_W'(ROUND_TICKS);
            end else begin
                case (state_q)
                    ST_INTRO: begin
                        if (phase_q == PHASE_W'(INTRO_TICKS - 1)) begin
                            state_d = ST_FIGHT;
                            phase_d = '0;
                            time_d  = TIME_W'(ROUND_TICKS);
                        end else begin
                            phase_d = phase_q + PHASE_W'(1);
                        end
                    end

                    // A double KO is checked first so neither player scores.
                    // The clock only runs out after a full tick at zero.
                    ST_FIGHT: begin
                        decided = 1'b1;
                        if ((health_1 == '0) && (health_2 == '0)) begin
                            rwin_d = 2'd3;
                        end else if (health_1 == '0) begin
                            rwin_d  = 2'd2;
                            wins2_d = sat_inc(wins2_q);
                        end else if (health_2 == '0) begin
                            rwin_d  = 2'd1;
                            wins1_d = sat_inc(wins1_q);
                        end else if (time_q == '0) begin
                            if (health_1 > health_2) begin
                                rwin_d  = 2'd1;
                                wins1_d = sat_inc(wins1_q);
                            end else if (health_2 > health_1) begin
                                rwin_d  = 2'd2;
                                wins2_d = sat_inc(wins2_q);
                            end else begin
                                rwin_d = 2'd3;
                            end
                        end else begin
                            time_d  = time_q - TIME_W'(1);
                            decided = 1'b0;
                        end

                        if (decided) begin
                            state_d = ST_KO;
                            phase_d = '0;
                        end
                    end

                    // When the round limit is hit without a clear match
                    // winner, the match goes to whoever has more wins.
                    ST_KO: begin
                        if (phase_q == PHASE_W'(KO_TICKS - 1)) begin
                            phase_d = '0;
                            if (wins1_q == 4'(ROUNDS_TO_WIN)) begin
                                winner_d = 3'd1;
                                state_d  = ST_MATCH_OVER;
                            end else if (wins2_q == 4'(ROUNDS_TO_WIN)) begin
                                winner_d = 3'd2;
                                state_d  = ST_MATCH_OVER;
                            end else if (round_q == 4'(MAX_ROUNDS)) begin
                                if (wins1_q > wins2_q) begin
                                    winner_d = 3'd1;
                                end else if (wins2_q > wins1_q) begin
                                    winner_d = 3'd2;
                                end else begin
                                    winner_d = 3'd3;
                                end
                                state_d = ST_MATCH_OVER;
                            end else begin
                                round_d = round_q + 4'd1;
                                state_d = ST_INTRO;
                            end
                        end else begin
                            phase_d = phase_q + PHASE_W'(1);
                        end
                    end

                    ST_MATCH_OVER: begin
                    end

                    default: begin
                        state_d = ST_INTRO;
                        phase_d = '0;
                    end
                endcase
            end
        end

        round_reset_d = (state_d == ST_INTRO);
        fight_en_d    = (state_d == ST_FIGHT);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_INTRO;
            div_q         <= '0;
            tick_q        <= 1'b0;
            phase_q       <= '0;
            hold_q        <= '0;
            round_q       <= 4'd1;
            wins1_q       <= 4'd0;
            wins2_q       <= 4'd0;
            rwin_q        <= 2'd0;
            winner_q      <= 3'd0;
            time_q        <= TIME_W'(ROUND_TICKS);
            round_reset_q <= 1'b1;
            fight_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            tick_q        <= tick_d;
            phase_q       <= phase_d;
            hold_q        <= hold_d;
            round_q       <= round_d;
            wins1_q       <= wins1_d;
            wins2_q       <= wins2_d;
            rwin_q        <= rwin_d;
            winner_q      <= winner_d;
            time_q        <= time_d;
            round_reset_q <= round_reset_d;
            fight_en_q    <= fight_en_d;
        end
    end

    assign tick         = tick_q;
    assign round_reset  = round_reset_q;
    assign fight_en     = fight_en_q;
    assign state        = state_q;
    assign round_num    = round_q;
    assign wins_1       = wins1_q;
    assign wins_2       = wins2_q;
    assign round_winner = rwin_q;
    assign winner       = winner_q;
    assign time_left    = time_q;

endmodule

// File: tb/tb_match_round_controller.sv
// -----------------------------------------------------------------------------
// tb_match_round_controller
//
// Drives a small, fast match configuration through a table of per-tick
// vectors (inputs applied before a tick, outputs expected after it), then
// runs hand-written sequences for tick spacing, health glitches between
// ticks and asynchronous reset in the middle of KO.
// -----------------------------------------------------------------------------
module tb_match_round_controller;

    localparam int TICK_DIV      = 4;
    localparam int HEALTH_W      = 9;
    localparam int ROUNDS_TO_WIN = 2;
    localparam int MAX_ROUNDS    = 2;
    localparam int ROUND_TICKS   = 10;
    localparam int INTRO_TICKS   = 3;
    localparam int KO_TICKS      = 2;
    localparam int HOLD_TICKS    = 4;
    localparam int TIME_W        = 11;

    logic                clk = 1'b0;
    logic                reset;
    logic                restart_req;
    logic [HEALTH_W-1:0] health_1;
    logic [HEALTH_W-1:0] health_2;
    logic                tick;
    logic                round_reset;
    logic                fight_en;
    logic [2:0]          state;
    logic [3:0]          round_num;
    logic [3:0]          wins_1;
    logic [3:0]          wins_2;
    logic [1:0]          round_winner;
    logic [2:0]          winner;
    logic [TIME_W-1:0]   time_left;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        logic r;
        int   h1;
        int   h2;
        int   st;
        int   rn;
        int   w1;
        int   w2;
        int   rw;
        int   win;
        int   tl;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    match_round_controller #(
        .TICK_DIV      (TICK_DIV),
        .HEALTH_W      (HEALTH_W),
        .ROUNDS_TO_WIN (ROUNDS_TO_WIN),
        .MAX_ROUNDS    (MAX_ROUNDS),
        .ROUND_TICKS   (ROUND_TICKS),
        .INTRO_TICKS   (INTRO_TICKS),
        .KO_TICKS      (KO_TICKS),
        .HOLD_TICKS    (HOLD_TICKS),
        .TIME_W        (TIME_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .restart_req  (restart_req),
        .health_1     (health_1),
        .health_2     (health_2),
        .tick         (tick),
        .round_reset  (round_reset),
        .fight_en     (fight_en),
        .state        (state),
        .round_num    (round_num),
        .wins_1       (wins_1),
        .wins_2       (wins_2),
        .round_winner (round_winner),
        .winner       (winner),
        .time_left    (time_left)
    );

    // Global time limit so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addVec(input logic r, input int h1, input int h2,
                                   input int st, input int rn, input int w1,
                                   input int w2, input int rw, input int win,
                                   input int tl);
        vec_t v;
        v.r = r; v.h1 = h1; v.h2 = h2; v.st = st; v.rn = rn;
        v.w1 = w1; v.w2 = w2; v.rw = rw; v.win = win; v.tl = tl;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertions++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Wait (bounded) for the next tick pulse, then one more clock so the
    // registers updated on that tick edge are visible at the falling edge.
    task automatic nextTick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (tick) seen = 1'b1;
        end
        checkOutput("tick_seen", int'(seen), 1);
        if (seen) @(negedge clk);
    endtask

    task automatic checkAll(input string tag, input int st, input int rn,
                            input int w1, input int w2, input int rw,
                            input int win, input int tl);
        checkOutput({tag, "_state"},        int'(state),        st);
        checkOutput({tag, "_round_num"},    int'(round_num),    rn);
        checkOutput({tag, "_wins_1"},       int'(wins_1),       w1);
        checkOutput({tag, "_wins_2"},       int'(wins_2),       w2);
        checkOutput({tag, "_round_winner"}, int'(round_winner), rw);
        checkOutput({tag, "_winner"},       int'(winner),       win);
        checkOutput({tag, "_time_left"},    int'(time_left),    tl);
        checkOutput({tag, "_round_reset"},  int'(round_reset),  (st == 0) ? 1 : 0);
        checkOutput({tag, "_fight_en"},     int'(fight_en),     (st == 1) ? 1 : 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        restart_req = v.r;
        health_1    = HEALTH_W'(v.h1);
        health_2    = HEALTH_W'(v.h2);
        nextTick();
    endtask

    task automatic buildTable();
        // Match A: P1 wins two KO rounds.
        addVec(0, 100, 100, 0, 1, 0, 0, 0, 0, 10);
        addVec(0, 100, 100, 0, 1, 0, 0, 0, 0, 10);
        addVec(0, 100, 100, 1, 1, 0, 0, 0, 0, 10);
        addVec(0, 100, 100, 1, 1, 0, 0, 0, 0, 9);
        addVec(0, 100, 100, 1, 1, 0, 0, 0, 0, 8);
        addVec(0, 100,   0, 2, 1, 1, 0, 1, 0, 8);
        addVec(0, 100, 100, 2, 1, 1, 0, 1, 0, 8);
        addVec(0, 100, 100, 0, 2, 1, 0, 1, 0, 8);
        addVec(0, 100, 100, 0, 2, 1, 0, 1, 0, 8);
        addVec(0, 100, 100, 0, 2, 1, 0, 1, 0, 8);
        addVec(0, 100, 100, 1, 2, 1, 0, 1, 0, 10);
        addVec(0, 100,   0, 2, 2, 2, 0, 1, 0, 10);
        addVec(0, 100, 100, 2, 2, 2, 0, 1, 0, 10);
        addVec(0, 100, 100, 3, 2, 2, 0, 1, 1, 10);
        addVec(0,   0,   0, 3, 2, 2, 0, 1, 1, 10);
        // Restart hold: 3 high, 1 low, then 4 high.
        for (int i = 0; i < 3; i++) addVec(1, 100, 100, 3, 2, 2, 0, 1, 1, 10);
        addVec(0, 100, 100, 3, 2, 2, 0, 1, 1, 10);
        for (int i = 0; i < 3; i++) addVec(1, 100, 100, 3, 2, 2, 0, 1, 1, 10);
        addVec(1, 100, 100, 0, 1, 0, 0, 0, 0, 10);

        // Match B: timeout win for P2, then double KO; P2 takes the match on wins.
        addVec(0, 100, 100, 0, 1, 0, 0, 0, 0, 10);
        addVec(0, 100, 100, 0, 1, 0, 0, 0, 0, 10);
        addVec(0,  50,  80, 1, 1, 0, 0, 0, 0, 10);
        for (int t = 9; t >= 0; t--) addVec(0, 50, 80, 1, 1, 0, 0, 0, 0, t);
        addVec(0,  50,  80, 2, 1, 0, 1, 2, 0, 0);
        addVec(0,  50,  80, 2, 1, 0, 1, 2, 0, 0);
        addVec(0, 100, 100, 0, 2, 0, 1, 2, 0, 0);
        addVec(0, 100, 100, 0, 2, 0, 1, 2, 0, 0);
        addVec(0, 100, 100, 0, 2, 0, 1, 2, 0, 0);
        addVec(0, 100, 100, 1, 2, 0, 1, 2, 0, 10);
        addVec(0,   0,   0, 2, 2, 0, 1, 3, 0, 10);
        addVec(0, 100, 100, 2, 2, 0, 1, 3, 0, 10);
        addVec(0, 100, 100, 3, 2, 0, 1, 3, 2, 10);
        for (int i = 0; i < 3; i++) addVec(1, 100, 100, 3, 2, 0, 1, 3, 2, 10);
        addVec(1, 100, 100, 0, 1, 0, 0, 0, 0, 10);

        // Match C: equal-health timeout draw, then double KO; match draw.
        // A 3-tick restart hold during FIGHT must not restart.
        addVec(0, 100, 100, 0, 1, 0, 0, 0, 0, 10);
        addVec(0, 100, 100, 0, 1, 0, 0, 0, 0, 10);
        addVec(0,  70,  70, 1, 1, 0, 0, 0, 0, 10);
        for (int t = 9; t >= 7; t--) addVec(1, 70, 70, 1, 1, 0, 0, 0, 0, t);
        for (int t = 6; t >= 0; t--) addVec(0, 70, 70, 1, 1, 0, 0, 0, 0, t);
        addVec(0,  70,  70, 2, 1, 0, 0, 3, 0, 0);
        addVec(0,  70,  70, 2, 1, 0, 0, 3, 0, 0);
        addVec(0, 100, 100, 0, 2, 0, 0, 3, 0, 0);
        addVec(0, 100, 100, 0, 2, 0, 0, 3, 0, 0);
        addVec(0, 100, 100, 0, 2, 0, 0, 3, 0, 0);
        addVec(0, 100, 100, 1, 2, 0, 0, 3, 0, 10);
        addVec(0,   0,   0, 2, 2, 0, 0, 3, 0, 10);
        addVec(0, 100, 100, 2, 2, 0, 0, 3, 0, 10);
        addVec(0, 100, 100, 3, 2, 0, 0, 3, 3, 10);
        for (int i = 0; i < 3; i++) addVec(1, 100, 100, 3, 2, 0, 0, 3, 3, 10);
        addVec(1, 100, 100, 0, 1, 0, 0, 0, 0, 10);

        // Match D: restart completed during FIGHT.
        addVec(0, 100, 100, 0, 1, 0, 0, 0, 0, 10);
        addVec(0, 100, 100, 0, 1, 0, 0, 0, 0, 10);
        addVec(0, 100, 100, 1, 1, 0, 0, 0, 0, 10);
        addVec(1, 100, 100, 1, 1, 0, 0, 0, 0, 9);
        addVec(1, 100, 100, 1, 1, 0, 0, 0, 0, 8);
        addVec(1, 100, 100, 1, 1, 0, 0, 0, 0, 7);
        addVec(1, 100, 100, 0, 1, 0, 0, 0, 0, 10);
    endtask

    initial begin
        int tickCount;

        reset       = 1'b0;
        restart_req = 1'b0;
        health_1    = HEALTH_W'(100);
        health_2    = HEALTH_W'(100);
        buildTable();

        repeat (3) @(negedge clk);
        checkAll("reset", 0, 1, 0, 0, 0, 0, 10);
        checkOutput("reset_tick", int'(tick), 0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkAll($sformatf("v%0d", i), vecs[i].st, vecs[i].rn, vecs[i].w1,
                     vecs[i].w2, vecs[i].rw, vecs[i].win, vecs[i].tl);
        end

        // Tick spacing: 40 clocks must hold exactly 10 single-cycle ticks.
        // Those ticks take INTRO (3) into FIGHT and count time_left 10 -> 3.
        restart_req = 1'b0;
        health_1    = HEALTH_W'(100);
        health_2    = HEALTH_W'(100);
        tickCount   = 0;
        repeat (40) begin
            @(negedge clk);
            if (tick) tickCount++;
        end
        checkOutput("tick_count_40clk", tickCount, 10);
        checkAll("after_40clk", 1, 1, 0, 0, 0, 0, 3);

        // Health glitch away from the tick cycle must be ignored.
        health_1 = HEALTH_W'(0);
        @(negedge clk);
        @(negedge clk);
        health_1 = HEALTH_W'(100);
        nextTick();
        checkAll("glitch", 1, 1, 0, 0, 0, 0, 2);

        // Enter KO, then assert async reset between ticks.
        health_2 = HEALTH_W'(0);
        nextTick();
        checkAll("ko_entry", 2, 1, 1, 0, 1, 0, 2);
        health_2 = HEALTH_W'(100);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkAll("async_reset", 0, 1, 0, 0, 0, 0, 10);
        checkOutput("async_reset_tick", int'(tick), 0);
        tickCount = 0;
        repeat (8) begin
            @(negedge clk);
            if (tick) tickCount++;
        end
        checkOutput("reset_no_tick", tickCount, 0);
        reset = 1'b1;
        nextTick();
        checkAll("post_reset", 0, 1, 0, 0, 0, 0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
